// File: rtl/pe_mac_accum_if.sv
// Handshake bundle for the MAC processing element: input beat stream and output psum stream.
interface pe_mac_accum_if #(
   parameter int I_X    = 8,
   parameter int I_W    = 8,
   parameter int I_PSUM = 16,
   parameter int O_PSUM = 24
);
   logic                     i_valid;
   logic                     o_ready;
   logic signed [I_X-1:0]    i_x;
   logic signed [I_W-1:0]    i_w;
   logic signed [I_PSUM-1:0] i_psum;
   logic                     o_valid;
   logic                     i_ready;
   logic signed [O_PSUM-1:0] o_psum;
   logic                     o_sat;

   modport slave (
      input  i_valid, i_x, i_w, i_psum, i_ready,
      output o_ready, o_valid, o_psum, o_sat
   );

   modport master (
      output i_valid, i_x, i_w, i_psum, i_ready,
      input  o_ready, o_valid, o_psum, o_sat
   );
endinterface

// File: rtl/pe_mac_accum.sv
// Multi-tap multiply-accumulate PE: psum + sum of K products (or one product in mode 0),
// saturated to O_PSUM bits on the way out.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a window (i_psum and i_mode sampled here)
//   ACC   | accumulating the remaining taps; bubbles hold acc/cnt
//   OUT   | result presented on o_psum/o_sat, input stalled until i_ready
module pe_mac_accum #(
   parameter int I_X    = 8,
   parameter int I_W    = 8,
   parameter int I_PSUM = 16,
   parameter int O_PSUM = 24,
   parameter int K      = 9
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_mode,
   pe_mac_accum_if.slave   bus
);
   localparam int PROD_W = I_X + I_W;
   localparam int GROW_W = PROD_W + $clog2(K);
   localparam int ACC_W  = ((I_PSUM > GROW_W) ? I_PSUM : GROW_W) + 2;
   // One bit wider than both the accumulator and the output so the clip compare is exact.
   localparam int EXT_W  = ((ACC_W > O_PSUM) ? ACC_W : O_PSUM) + 1;
   localparam int CNT_W  = $clog2(K + 1);

   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-O_PSUM+1){1'b0}}, {(O_PSUM-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-O_PSUM+1){1'b1}}, {(O_PSUM-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  sum;
   logic signed [EXT_W-1:0]  sum_ext;
   logic signed [EXT_W-1:0]  sat_val;
   logic                     sat_hit;
   logic                     accept;
   logic                     last_beat;

   assign bus.o_ready = (state != OUT) && i_rst_n;
   assign accept      = bus.i_valid && bus.o_ready;

   // Next accumulator value for an accepted beat and its saturated output form.
   always_comb begin
      prod     = bus.i_x * bus.i_w;
      prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      base     = (state == IDLE) ? {{(ACC_W-I_PSUM){bus.i_psum[I_PSUM-1]}}, bus.i_psum} : acc;
      sum      = base + prod_ext;
      sum_ext  = {{(EXT_W-ACC_W){sum[ACC_W-1]}}, sum};
      sat_val  = sum_ext;
      sat_hit  = 1'b0;
      if (sum_ext > SAT_MAX) begin
         sat_val = SAT_MAX;
         sat_hit = 1'b1;
      end else if (sum_ext < SAT_MIN) begin
         sat_val = SAT_MIN;
         sat_hit = 1'b1;
      end
      // Mode only matters on the first beat; afterwards the window length is fixed by cnt.
      last_beat = ((state == IDLE) && (!i_mode || (K == 1))) ||
                  ((state == ACC) && (cnt == CNT_W'(K - 1)));
   end

   // Window sequencing, accumulation and registered output.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         bus.o_psum  <= '0;
         bus.o_valid <= 1'b0;
         bus.o_sat   <= 1'b0;
      end else if (i_clear) begin
         // o_psum deliberately keeps the last delivered result.
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         bus.o_valid <= 1'b0;
         bus.o_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  acc <= sum;
                  cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
                  if (last_beat) begin
                     bus.o_psum  <= sat_val[O_PSUM-1:0];
                     bus.o_sat   <= sat_hit;
                     bus.o_valid <= 1'b1;
                     state       <= OUT;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            OUT: begin
               if (bus.i_ready) begin
                  bus.o_valid <= 1'b0;
                  cnt         <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
